// File: rtl/hmac_drv_pkg.sv
// hmac_drv_pkg: shared widths and FSM states for the HMAC-384 command driver.
package hmac_drv_pkg;
    localparam int KEY_W       = 384;
    localparam int TAG_W       = 384;
    localparam int BLOCK_W     = 1024;
    localparam int BLOCK_WORDS = 32;
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/hmac_blk_packer.sv
// hmac_blk_packer: shifts 32-bit words into a block register, first word ending at the MSB end.
module hmac_blk_packer #(
    parameter int WORDS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [31:0]           data,
    output logic                  last_word,
    output logic [WORDS*32-1:0]   block
);
    localparam int CW = $clog2(WORDS);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            block <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt   <= cnt + 1'b1;
            block <= {block[WORDS*32-33:0], data};
        end
    end
    assign last_word = cnt == CW'(WORDS - 1);
endmodule

// File: rtl/hmac_drv.sv
// hmac_drv: loads key and one message block, issues init to hmac_core and captures the tag.
// Tag comparison against expected_tag is built only when HMAC_DRV_TAG_CMP_EN is defined.
module hmac_drv
    import hmac_drv_pkg::*;
#(
    parameter int BLOCK_WORDS = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [KEY_W-1:0]        key,
    input  logic                    msg_wr_valid,
    input  logic [31:0]             msg_wr_data,
    output logic                    msg_wr_ready,
    output logic                    busy,
    output logic                    done,
    output logic [TAG_W-1:0]        tag_out,
    input  logic [TAG_W-1:0]        expected_tag,
    output logic                    tag_match,
    output logic                    core_init_cmd,
    output logic                    core_next_cmd,
    input  logic                    core_ready,
    input  logic                    core_tag_valid,
    output logic [KEY_W-1:0]        core_key,
    output logic [BLOCK_WORDS*32-1:0] core_block_msg,
    input  logic [TAG_W-1:0]        core_tag
);
    state_t state;
    logic   last_word;
    logic   word_en;
    logic   begin_op;

    assign begin_op      = state == IDLE && start;
    assign word_en       = msg_wr_valid && msg_wr_ready && !abort;
    assign core_init_cmd = state == ISSUE && core_ready;
    assign core_next_cmd = 1'b0;

    hmac_blk_packer #(.WORDS(BLOCK_WORDS)) u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (begin_op),
        .en        (word_en),
        .data      (msg_wr_data),
        .last_word (last_word),
        .block     (core_block_msg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            core_key     <= '0;
            tag_out      <= '0;
            msg_wr_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    core_key     <= key;
                    msg_wr_ready <= 1'b1;
                    busy         <= 1'b1;
                    state        <= LOAD;
                end
                LOAD: if (abort) begin
                    msg_wr_ready <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end else if (word_en && last_word) begin
                    msg_wr_ready <= 1'b0;
                    state        <= ISSUE;
                end
                ISSUE: if (core_ready) state <= WAIT;
                WAIT: if (core_tag_valid) begin
                    tag_out <= core_tag;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HMAC_DRV_TAG_CMP_EN
    logic match_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) match_q <= 1'b0;
        else if (begin_op) match_q <= 1'b0;
        else if (state == WAIT && core_tag_valid) match_q <= core_tag == expected_tag;
    end
    assign tag_match = match_q;
`else
    logic unused_expected;
    assign unused_expected = ^expected_tag;
    assign tag_match = 1'b0;
`endif
endmodule

// File: tb/tb_hmac_drv.sv
// tb_hmac_drv: directed scoreboard bench for hmac_drv with a behavioural hmac_core stub.
module tb_hmac_drv;
    import hmac_drv_pkg::*;

    localparam logic [383:0] K1 = {224'h0, {20{8'h0b}}};
    localparam logic [1023:0] B1 = {64'h4869205468657265, 8'h80, 824'h0, 128'h440};
    localparam logic [383:0] KNOWN = 384'hafd03944d84895626b0825f4ab46907f15f9dadbe4101ec682aa034c7cebc59cfaea9ea9076ede7f4af152e8b2fa9cb6;
`ifdef HMAC_DRV_TAG_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 0, reset_n = 0, start = 0, abort = 0;
    logic [383:0] key = '0, expected_tag = '0, tag_out, core_key, core_tag;
    logic msg_wr_valid = 0, msg_wr_ready, busy, done, tag_match;
    logic [31:0] msg_wr_data = '0;
    logic core_init_cmd, core_next_cmd, core_ready, core_tag_valid;
    logic [1023:0] core_block_msg;

    int compared = 0, mismatched = 0;
    int init_cnt = 0, done_cnt = 0, lat = 4;
    logic ready_en = 1'b1;
    logic run = 1'b0;
    int cnt = 0;
    logic [383:0] exp_tag_q[$];
    logic exp_match_q[$];
    logic [383:0] last_tag = '0;

    always #5 clk = ~clk;

    hmac_drv dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key),
        .msg_wr_valid(msg_wr_valid), .msg_wr_data(msg_wr_data), .msg_wr_ready(msg_wr_ready),
        .busy(busy), .done(done), .tag_out(tag_out), .expected_tag(expected_tag),
        .tag_match(tag_match), .core_init_cmd(core_init_cmd), .core_next_cmd(core_next_cmd),
        .core_ready(core_ready), .core_tag_valid(core_tag_valid), .core_key(core_key),
        .core_block_msg(core_block_msg), .core_tag(core_tag)
    );

    // Stand-in for hmac_core: answers the known vector, otherwise a fixed fold of key and block.
    function automatic logic [383:0] core_model(input logic [383:0] k, input logic [1023:0] b);
        if (k == K1 && b == B1) return KNOWN;
        return b[1023:640] ^ b[639:256] ^ {b[255:0], b[1023:896]} ^ {k[191:0], k[383:192]};
    endfunction

    assign core_ready = ready_en && !run;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0; cnt <= 0; core_tag_valid <= 1'b0; core_tag <= '0;
        end else if (core_init_cmd) begin
            run <= 1'b1; cnt <= lat; core_tag_valid <= 1'b0;
        end else if (run) begin
            if (cnt == 0) begin
                run <= 1'b0; core_tag_valid <= 1'b1; core_tag <= core_model(core_key, core_block_msg);
            end else cnt <= cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (core_init_cmd) init_cnt <= init_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [1023:0] obs, input logic [1023:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic start_op(input logic [383:0] k);
        @(negedge clk);
        start = 1'b1; key = k;
        @(negedge clk);
        start = 1'b0; key = '0;
    endtask

    task automatic send(input logic [1023:0] blk, input int n, input int gap_at, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at && gap > 0) begin
                msg_wr_valid = 1'b0;
                repeat (gap) @(negedge clk);
                chk("gap_still_load", 1024'(dut.state), 1024'(LOAD));
            end
            msg_wr_valid = 1'b1;
            msg_wr_data = blk[1023-32*i -: 32];
            if (i == 31) chk("load_before_last", 1024'(dut.state), 1024'(LOAD));
            @(negedge clk);
        end
        msg_wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic [383:0] et;
        logic em;
        int n;
        et = exp_tag_q.pop_front();
        em = exp_match_q.pop_front();
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, 1024'(done), 1024'(1));
        if (done === 1'b1) begin
            chk({nm, "_tag"}, 1024'(tag_out), 1024'(et));
            chk({nm, "_match"}, 1024'(tag_match), 1024'(em));
            @(negedge clk);
            chk({nm, "_idle_after"}, {1020'(dut.state), done, busy, 2'b0}, {1020'(IDLE), 4'b0});
            last_tag = et;
        end
    endtask

    task automatic push(input logic [383:0] t);
        exp_tag_q.push_back(t);
        exp_match_q.push_back(CMP && (expected_tag == t));
    endtask

    task automatic reach_wait();
        int n;
        n = 0;
        while (dut.state !== WAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait", 1024'(dut.state), 1024'(WAIT));
    endtask

    initial begin
        logic [1023:0] rb;
        logic [383:0] rk;
        int i0, d0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {1017'b0, msg_wr_ready, busy, done, tag_match, core_init_cmd, core_next_cmd, |tag_out},
            1024'(0));
        chk("rst_key_blk", {1022'b0, |core_key, |core_block_msg}, 1024'(0));
        chk("rst_state", 1024'(dut.state), 1024'(IDLE));
        reset_n = 1'b1;

        // Known vector, gapless
        expected_tag = KNOWN;
        i0 = init_cnt; d0 = done_cnt;
        start_op(K1);
        chk("ready_after_start", {1022'b0, msg_wr_ready, busy}, 1024'(3));
        send(B1, 32, 99, 0);
        chk("issue_after_32", {1020'(dut.state), msg_wr_ready}, {1020'(ISSUE), 1'b0});
        push(KNOWN);
        wait_done("vec");
        chk("vec_init_once", 1024'(init_cnt - i0), 1024'(1));
        chk("vec_done_once", 1024'(done_cnt - d0), 1024'(1));

        // Gap after word 10, expected tag differs in one bit
        expected_tag = KNOWN ^ 384'h1;
        start_op(K1);
        chk("match_cleared_on_start", 1024'(tag_match), 1024'(0));
        send(B1, 32, 10, 7);
        push(KNOWN);
        wait_done("gap");

        // core_ready held low in ISSUE
        ready_en = 1'b0;
        for (int i = 0; i < 32; i++) rb[32*i +: 32] = $urandom;
        for (int i = 0; i < 12; i++) rk[32*i +: 32] = $urandom;
        i0 = init_cnt;
        start_op(rk);
        send(rb, 32, 99, 0);
        repeat (5) begin
            chk("init_low_not_ready", 1024'(core_init_cmd), 1024'(0));
            @(negedge clk);
        end
        chk("held_in_issue", {1020'(dut.state), 1'b0}, {1020'(ISSUE), 1'b0});
        ready_en = 1'b1;
        push(core_model(rk, rb));
        wait_done("rdy");
        chk("rdy_init_once", 1024'(init_cnt - i0), 1024'(1));

        // Abort after 16 words, then a full run
        i0 = init_cnt;
        start_op(K1);
        send(rb, 16, 99, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {1020'(dut.state), busy, msg_wr_ready}, {1020'(IDLE), 2'b0});
        repeat (3) @(negedge clk);
        chk("abort_no_init", 1024'(init_cnt - i0), 1024'(0));
        expected_tag = KNOWN;
        start_op(K1);
        send(B1, 32, 99, 0);
        push(KNOWN);
        wait_done("post_abort");

        // start and abort pulsed in WAIT are ignored
        lat = 20;
        start_op(rk);
        send(rb, 32, 99, 0);
        push(core_model(rk, rb));
        reach_wait();
        start = 1'b1; abort = 1'b1; key = K1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; key = '0;
        chk("wait_ignores_cmds", 1024'(dut.state), 1024'(WAIT));
        chk("tag_held_in_wait", 1024'(tag_out), 1024'(last_tag));
        wait_done("wait_pulse");

        // Reset asserted in WAIT, then a full run
        start_op(K1);
        send(B1, 32, 99, 0);
        reach_wait();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wait_outs", {1017'b0, msg_wr_ready, busy, done, tag_match, core_init_cmd, core_next_cmd, |tag_out},
            1024'(0));
        chk("rst_wait_regs", {1019'(dut.state), |core_key, |core_block_msg}, {1019'(IDLE), 2'b0});
        @(negedge clk);
        reset_n = 1'b1;
        lat = 4;
        start_op(K1);
        send(B1, 32, 99, 0);
        push(KNOWN);
        wait_done("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/hmac_drv.md
# hmac_drv

Command-side initiator for the HMAC-384 core. It accepts a 384-bit key and one pre-padded 1024-bit message block, streamed as 32-bit words, and packs the words into a block register. It issues a single-cycle `init_cmd` handshake to the core, waits for the tag, then captures and presents the 384-bit tag. Optionally, it compares the tag against an expected value. It sits between the register/firmware interface and `hmac_core`, and owns all sequencing of that core.

## Interface
Parameters:
- `BLOCK_WORDS`, 32: 32-bit words per message block; fixed by the 1024-bit block width.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an operation; honoured only in IDLE.
- `abort`  in  1  return to IDLE; honoured only in LOAD.
- `key`  in  384  HMAC key; sampled on the `start` cycle.
- `msg_wr_valid`  in  1  message word valid.
- `msg_wr_data`  in  32  message word; the first word lands in bits [1023:992].
- `msg_wr_ready`  out  1  high only in LOAD.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the tag is captured.
- `tag_out`  out  384  captured tag; held until the next `start`.
- `expected_tag`  in  384  reference tag; used only when HMAC_DRV_TAG_CMP_EN is defined.
- `tag_match`  out  1  compare result; valid while `tag_out` is valid.
- `core_init_cmd`  out  1  to `hmac_core.init_cmd`.
- `core_next_cmd`  out  1  to `hmac_core.next_cmd`; tied 0.
- `core_ready`  in  1  from `hmac_core.ready`.
- `core_tag_valid`  in  1  from `hmac_core.tag_valid`; a level signal.
- `core_key`  out  384  registered key to the core.
- `core_block_msg`  out  1024  registered block to the core.
- `core_tag`  in  384  from `hmac_core.tag`.

## Operation
- **IDLE**
  - On `start`: `key_reg <= key`, word counter <= 0, `tag_match <= 0`, go to LOAD.
- **LOAD**
  - Each `msg_wr_valid && msg_wr_ready` shifts the word into the block register, first word in the MSB end, and increments the 5-bit counter.
  - The word accepted at count 31 wraps the counter to 0 and moves the FSM to ISSUE.
  - `msg_wr_valid` is ignored outside LOAD.
  - `abort` in LOAD returns to IDLE. The block register is not cleared.
- **ISSUE**
  - `core_init_cmd = core_ready`, combinationally and only in this state.
  - When `core_ready` is high, go to WAIT. Otherwise stay in ISSUE with `core_init_cmd` at 0.
- **WAIT**
  - On `core_tag_valid == 1`: `tag_reg <= core_tag`, `tag_match <= (core_tag == expected_tag)`, go to DONE.
  - `abort` is ignored; the core cannot be stopped.
- **DONE**
  - `done = 1` for one cycle, then go to IDLE.
- `core_key` and `core_block_msg` are registers. They remain stable from leaving LOAD until the next `start`, because the core reads them combinationally across several of its own states.
- `start` while `busy` is ignored.
- `start` and `abort` together in IDLE: `start` wins.
- Reset mid-operation: every register returns to its reset value. The core shares `reset_n`, so there is no stale handshake.

## Timing
- Reset values are 0 for: `msg_wr_ready`, `busy`, `done`, `tag_out`, `tag_match`, `core_init_cmd`, `core_next_cmd`, `core_key`, `core_block_msg`. The FSM resets to IDLE.
- `start` sampled at edge E: LOAD from E+1, so `msg_wr_ready` is high in cycle E+1.
- Back-to-back valid words: 32 cycles in LOAD, then ISSUE on the following cycle.
- `core_init_cmd` is high for exactly one cycle per operation.
- The core clears `tag_valid` on the same edge it accepts init, so WAIT never sees a stale tag.
- `core_tag_valid` observed high in cycle T: `tag_out` and `tag_match` are valid from T+1, `done` is high in T+1, and the FSM is in IDLE at T+2.
- Total latency, `start` to `done`: 1 + 32 + ISSUE wait + core latency + 2 cycles.

## Configuration
- `HMAC_DRV_TAG_CMP_EN` defined:
  - A 384-bit comparator is built.
  - `tag_match` is registered as described in Operation.
- `HMAC_DRV_TAG_CMP_EN` undefined:
  - No comparator is built.
  - `expected_tag` is unused.
  - `tag_match` is tied 0.

## Structure
- Package `hmac_drv_pkg` holds:
  - the state enum (IDLE, LOAD, ISSUE, WAIT, DONE);
  - the localparams KEY_W=384, TAG_W=384, BLOCK_W=1024, BLOCK_WORDS=32.
- Sub-module `hmac_blk_packer` contains:
  - the 1024-bit shift register and 5-bit counter;
  - outputs `last_word` and `block`;
  - an enable input from the FSM.

## Test plan
- Key `0x0b` repeated ×20 zero-extended to 384 bits, standard pre-padded "Hi There" block → `tag_out` equals the HMAC-SHA384 known value; `done` pulses once; `core_init_cmd` is high for exactly 1 cycle.
- Gap in `msg_wr_valid` after word 10 for 7 cycles → identical tag to the gapless run; FSM enters ISSUE only after the 32nd accepted word.
- Hold `core_ready` = 0 for 5 cycles in ISSUE (core stub) → `core_init_cmd` stays 0, then pulses 1 cycle once `core_ready` rises.
- `abort` after 16 words → IDLE next cycle; `busy` = 0; no `core_init_cmd`. A following `start` with 32 words yields the correct tag.
- `start` pulsed in WAIT, and `abort` pulsed in WAIT → both ignored; `tag_out` unchanged until `done`.
- With `HMAC_DRV_TAG_CMP_EN` defined: `expected_tag` equal to the known tag → `tag_match` = 1; one bit flipped → `tag_match` = 0. Without the macro: `tag_match` = 0 in both cases.
- Assert `reset_n` in WAIT → all outputs 0 and FSM in IDLE; a subsequent full operation is correct.
